// File: rtl/ssd_pkg.sv
// Shared definitions for the scanned seven-segment reader: the active-low hex
// glyph table (bit 6 = g ... bit 0 = a), the blank pattern and the FSM state type.
package ssd_pkg;

    localparam logic [6:0] SSD_GLYPH_0 = 7'h40;
    localparam logic [6:0] SSD_GLYPH_1 = 7'h79;
    localparam logic [6:0] SSD_GLYPH_2 = 7'h24;
    localparam logic [6:0] SSD_GLYPH_3 = 7'h30;
    localparam logic [6:0] SSD_GLYPH_4 = 7'h19;
    localparam logic [6:0] SSD_GLYPH_5 = 7'h12;
    localparam logic [6:0] SSD_GLYPH_6 = 7'h02;
    localparam logic [6:0] SSD_GLYPH_7 = 7'h78;
    localparam logic [6:0] SSD_GLYPH_8 = 7'h00;
    localparam logic [6:0] SSD_GLYPH_9 = 7'h10;
    localparam logic [6:0] SSD_GLYPH_A = 7'h08;
    localparam logic [6:0] SSD_GLYPH_B = 7'h03;
    localparam logic [6:0] SSD_GLYPH_C = 7'h46;
    localparam logic [6:0] SSD_GLYPH_D = 7'h21;
    localparam logic [6:0] SSD_GLYPH_E = 7'h06;
    localparam logic [6:0] SSD_GLYPH_F = 7'h0E;

    localparam logic [6:0] SSD_BLANK   = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ssd_state_e;

endpackage

// File: rtl/ssd_scan_reader_if.sv
// Capture output channel. A capture transfers on a clock edge where out_valid and
// out_ready are both high; the producer holds out_idx/out_value/out_err stable while out_valid is high.
interface ssd_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [3:0]       out_value;
    logic             out_err;

    modport master (output out_valid, out_idx, out_value, out_err, input out_ready);
    modport slave  (input out_valid, out_idx, out_value, out_err, output out_ready);

endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational inverse of the hex glyph table: a 7-bit active-low segment
// pattern maps back to its 4-bit value, or raises err (value 0) when no glyph matches.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       err
);

    always_comb begin
        value = 4'h0;
        err   = 1'b0;
        case (seg)
            SSD_GLYPH_0: value = 4'h0;
            SSD_GLYPH_1: value = 4'h1;
            SSD_GLYPH_2: value = 4'h2;
            SSD_GLYPH_3: value = 4'h3;
            SSD_GLYPH_4: value = 4'h4;
            SSD_GLYPH_5: value = 4'h5;
            SSD_GLYPH_6: value = 4'h6;
            SSD_GLYPH_7: value = 4'h7;
            SSD_GLYPH_8: value = 4'h8;
            SSD_GLYPH_9: value = 4'h9;
            SSD_GLYPH_A: value = 4'hA;
            SSD_GLYPH_B: value = 4'hB;
            SSD_GLYPH_C: value = 4'hC;
            SSD_GLYPH_D: value = 4'hD;
            SSD_GLYPH_E: value = 4'hE;
            SSD_GLYPH_F: value = 4'hF;
            default:     err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_scan_reader.sv
// Receive side of a multiplexed HEX display: debounces the scanned segment/select bus,
// decodes each stable glyph and reports it per digit. Optional: SSD_SCAN_READER_CHANGE_FILTER_EN.
module ssd_scan_reader
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    ssd_scan_reader_if.master       out_if,
    output logic [4*NUM_DIGITS-1:0] digits_flat,
    output logic                    overrun,
    input  logic                    clr_overrun,
    output ssd_state_e              dbg_state
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [6:0]              smp_seg_q;
    logic [NUM_DIGITS-1:0]   smp_sel_q;
    logic [3:0]              cnt_q, cnt_d;
    logic                    emitted_q, emitted_d;
    ssd_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              val_q, val_d;
    logic                    err_q, err_d;
    logic [4*NUM_DIGITS-1:0] flat_q, flat_d;
    logic                    ovr_q, ovr_d;

    logic                    sample_chg;
    logic                    capture;
    logic                    suppress;
    logic                    report;
    logic [IDX_W-1:0]        cap_idx;
    logic [3:0]              dec_val;
    logic                    dec_err;

    ssd_glyph_decode u_decode (
        .seg   (smp_seg_q),
        .value (dec_val),
        .err   (dec_err)
    );

    // cnt_q counts repeats after the first sample, so STABLE_CYCLES identical samples show as STABLE_CYCLES-1.
    always_comb begin
        sample_chg = ({seg_in, dig_sel} != {smp_seg_q, smp_sel_q});
        cnt_d      = sample_chg ? 4'd0
                   : (cnt_q == 4'(STABLE_CYCLES)) ? cnt_q : cnt_q + 4'd1;
        capture    = (cnt_q >= 4'(STABLE_CYCLES - 1)) && $onehot(smp_sel_q) && !emitted_q;
        emitted_d  = sample_chg ? 1'b0 : (capture ? 1'b1 : emitted_q);

        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (smp_sel_q[i]) cap_idx = IDX_W'(i);
        end

        flat_d = flat_q;
        if (capture && !dec_err) flat_d[cap_idx*4 +: 4] = dec_val;

`ifdef SSD_SCAN_READER_CHANGE_FILTER_EN
        suppress = !dec_err && (flat_q[cap_idx*4 +: 4] == dec_val);
`else
        suppress = 1'b0;
`endif
        report = capture && !suppress;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        err_d   = err_q;
        ovr_d   = ovr_q & ~clr_overrun;
        case (state_q)
            IDLE: begin
                if (report) state_d = PEND;
            end
            PEND: begin
                if (!out_if.out_ready && report) ovr_d = 1'b1;
                else if (out_if.out_ready && !report) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Load whenever the channel is free this edge: idle, or the held capture transfers now.
        if (report && (state_q == IDLE || out_if.out_ready)) begin
            idx_d = cap_idx;
            val_d = dec_err ? 4'h0 : dec_val;
            err_d = dec_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_seg_q <= '0;
            smp_sel_q <= '0;
            cnt_q     <= '0;
            emitted_q <= 1'b0;
            state_q   <= IDLE;
            idx_q     <= '0;
            val_q     <= '0;
            err_q     <= 1'b0;
            flat_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            smp_seg_q <= seg_in;
            smp_sel_q <= dig_sel;
            cnt_q     <= cnt_d;
            emitted_q <= emitted_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            err_q     <= err_d;
            flat_q    <= flat_d;
            ovr_q     <= ovr_d;
        end
    end

    assign out_if.out_valid = (state_q == PEND);
    assign out_if.out_idx   = idx_q;
    assign out_if.out_value = val_q;
    assign out_if.out_err   = err_q;
    assign digits_flat      = flat_q;
    assign overrun          = ovr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Directed plus randomized bench for ssd_scan_reader against a run-length based
// behavioural model of the scanned display reader.
module tb_ssd_scan_reader;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int IW = 2;
`ifdef SSD_SCAN_READER_CHANGE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic [ND-1:0] dig_sel = '0;
  logic out_ready = 1'b0;
  logic clr_overrun = 1'b0;
  logic [4*ND-1:0] digits_flat;
  logic overrun;
  ssd_pkg::ssd_state_e dbg_state;

  always #5 clk = ~clk;

  ssd_scan_reader_if #(.NUM_DIGITS(ND)) out_if ();
  assign out_if.out_ready = out_ready;

  ssd_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .out_if      (out_if),
    .digits_flat (digits_flat),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .dbg_state   (dbg_state)
  );

  int n_assert = 0;
  int n_fail = 0;
  int vcnt = 0;

  // Glyph table of the display encoder (active-low, g..a), indexed by value.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: last applied sample, how many edges in a row it has been sampled,
  // the pending capture, per-digit last good value and the sticky overrun.
  logic [6:0] m_last_seg;
  logic [ND-1:0] m_last_sel;
  int m_run;
  bit m_pend;
  int m_idx, m_val;
  bit m_err;
  int m_flat [ND];
  bit m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] s, output int v, output bit e);
    v = 0;
    e = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (glyph[k] == s) begin
        v = k;
        e = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    m_last_seg = '0;
    m_last_sel = '0;
    m_run = 1;
    m_pend = 1'b0;
    m_idx = 0;
    m_val = 0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    for (int k = 0; k < ND; k++) m_flat[k] = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    bit cap, rep, drop, e;
    int v, i;
    cap = (m_run == SC) && ($countones(m_last_sel) == 1);
    rep = 1'b0;
    drop = 1'b0;
    i = 0;
    v = 0;
    e = 1'b0;
    if (cap) begin
      for (int k = 0; k < ND; k++) if (m_last_sel[k]) i = k;
      ref_decode(m_last_seg, v, e);
      rep = !(FILTER && !e && m_flat[i] == v);
      if (!e) m_flat[i] = v;
    end
    if (m_pend && out_ready) m_pend = 1'b0;
    if (rep) begin
      if (!m_pend) begin
        m_pend = 1'b1;
        m_idx = i;
        m_val = e ? 0 : v;
        m_err = e;
      end else begin
        drop = 1'b1;
      end
    end
    m_ovr = drop ? 1'b1 : (clr_overrun ? 1'b0 : m_ovr);
    if ({seg_in, dig_sel} == {m_last_seg, m_last_sel}) begin
      if (m_run <= SC) m_run++;
    end else begin
      m_run = 1;
      m_last_seg = seg_in;
      m_last_sel = dig_sel;
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(out_if.out_valid), 32'(m_pend));
    if (m_pend) begin
      check("idx", 32'(out_if.out_idx), 32'(m_idx));
      check("value", 32'(out_if.out_value), 32'(m_val));
      check("err", 32'(out_if.out_err), 32'(m_err));
    end
    for (int k = 0; k < ND; k++) check("digits_flat", 32'(digits_flat[4*k +: 4]), 32'(m_flat[k]));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (out_if.out_valid === 1'b1) vcnt++;
  endtask

  task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input logic rdy, input logic clr);
    seg_in = s;
    dig_sel = d;
    out_ready = rdy;
    clr_overrun = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [6:0] s, input logic [ND-1:0] d, input logic rdy, input int n);
    for (int k = 0; k < n; k++) step(s, d, rdy, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_reset();
      #1;
      compare_all();
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [ND-1:0] sel;
    logic [6:0] s;
    #1;
    do_reset(2);
    check("rst_idx", 32'(out_if.out_idx), 32'd0);
    check("rst_value", 32'(out_if.out_value), 32'd0);
    check("rst_err", 32'(out_if.out_err), 32'd0);
    check("rst_flat", 32'(digits_flat), 32'd0);

    // Glyph 0 on digit 0 from edge 0: reported after edge 3.
    hold(7'h40, 4'b0001, 1'b1, 3);
    check("lat_early", 32'(out_if.out_valid), 32'd0);
    step(7'h40, 4'b0001, 1'b1, 1'b0);
    check("lat_valid", 32'(out_if.out_valid), 32'(!FILTER));
    check("lat_flat0", 32'(digits_flat[3:0]), 32'd0);
    hold(7'h40, 4'b0001, 1'b1, 3);

    // Toggling every two cycles never settles; then hold 2 on digit 2.
    vcnt = 0;
    for (int k = 0; k < 6; k++) hold((k % 2 == 0) ? 7'h79 : 7'h24, 4'b0100, 1'b1, 2);
    check("toggle_none", 32'(vcnt), 32'd0);
    hold(7'h24, 4'b0100, 1'b1, 3);
    check("hold2_idx", 32'(out_if.out_idx), 32'd2);
    check("hold2_value", 32'(out_if.out_value), 32'd2);
    hold(7'h24, 4'b0100, 1'b1, 2);

    // Multi-hot and zero-hot selects never capture.
    vcnt = 0;
    hold(7'h19, 4'b0011, 1'b1, 10);
    hold(7'h19, 4'b0000, 1'b1, 10);
    check("bad_sel_none", 32'(vcnt), 32'd0);

    // Blank then 5 on digit 1.
    hold(7'h7F, 4'b0010, 1'b1, 3);
    step(7'h7F, 4'b0010, 1'b1, 1'b0);
    check("blank_err", 32'(out_if.out_err), 32'd1);
    check("blank_flat1", 32'(digits_flat[7:4]), 32'd0);
    hold(7'h12, 4'b0010, 1'b1, 3);
    step(7'h12, 4'b0010, 1'b1, 1'b0);
    check("five_value", 32'(out_if.out_value), 32'd5);
    hold(7'h12, 4'b0010, 1'b1, 2);

    // Back-pressure: 8 on digit 3 held, 1 on digit 0 dropped.
    hold(7'h00, 4'b1000, 1'b0, 5);
    hold(7'h79, 4'b0001, 1'b0, 5);
    check("ovr_idx", 32'(out_if.out_idx), 32'd3);
    check("ovr_value", 32'(out_if.out_value), 32'd8);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_flat0", 32'(digits_flat[3:0]), 32'd1);
    step(7'h79, 4'b0001, 1'b0, 1'b1);
    check("ovr_clr", 32'(overrun), 32'd0);
    hold(7'h79, 4'b0001, 1'b1, 2);

    // Reset while a capture is pending.
    hold(7'h06, 4'b0100, 1'b0, 5);
    do_reset(1);
    check("rst_pend", 32'(out_if.out_valid), 32'd0);

    // Same value twice on digit 2 separated by a blank.
    vcnt = 0;
    hold(7'h46, 4'b0100, 1'b1, 5);
    hold(7'h7F, 4'b0100, 1'b1, 5);
    hold(7'h46, 4'b0100, 1'b1, 5);
    check("filter_count", 32'(vcnt), FILTER ? 32'd2 : 32'd3);

    // Randomized windows against the model.
    for (int w = 0; w < 60; w++) begin
      int n;
      s = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : glyph[$urandom_range(0, 15)];
      sel = ($urandom_range(0, 4) == 0) ? ND'($urandom_range(0, 15)) : ND'(1 << $urandom_range(0, ND - 1));
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++)
        step(s, sel, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0));
    end
    hold(7'h7F, 4'b0000, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
